// File: rtl/alu_issue_pkg.sv
// Shared codes, field positions, FSM state and decode record for the ALU issue controller.
// The optional ALU_ISSUE_BRANCH_EN build adds bne/blt decode in the users of this package.
package alu_issue_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 27;
    localparam int RD_MSB    = 26;
    localparam int RD_LSB    = 22;
    localparam int SHAMT_MSB = 11;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_MSB = 6;
    localparam int ALUOP_LSB = 2;
    localparam int IMM_MSB   = 16;

    localparam logic [4:0]        RSTATUS_REG_DEF = 5'd30;
    localparam logic [DATA_W-1:0] EXC_ADD_DEF     = 32'd1;
    localparam logic [DATA_W-1:0] EXC_ADDI_DEF    = 32'd2;
    localparam logic [DATA_W-1:0] EXC_SUB_DEF     = 32'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // exc_code == 0 means overflow is not reported for this instruction.
    typedef struct packed {
        logic [4:0]        opcode;
        logic [4:0]        shamt;
        logic              opb_imm;
        logic [4:0]        rd;
        logic [DATA_W-1:0] exc_code;
        logic              is_branch;
        logic              br_lt;
        logic              illegal;
    } decode_t;

    function automatic logic [DATA_W-1:0] sign_extend_imm(input logic [IMM_MSB:0] imm);
        return {{(DATA_W-IMM_MSB-1){imm[IMM_MSB]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction-in and writeback-out bundle of the ALU issue controller.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// the sender holds its payload stable while valid is high and ready is low.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_opA;
    logic [31:0] in_opB;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
`ifdef ALU_ISSUE_BRANCH_EN
    logic        br_valid;
    logic        br_taken;
`endif

    // master: the issue controller; slave: upstream regfile-read and downstream writeback
    modport master (
`ifdef ALU_ISSUE_BRANCH_EN
        output br_valid, output br_taken,
`endif
        input  in_valid, output in_ready, input in_instr, input in_opA, input in_opB,
        output wb_valid, input wb_ready, output wb_we, output wb_rd, output wb_data,
        output illegal
    );

    modport slave (
`ifdef ALU_ISSUE_BRANCH_EN
        input  br_valid, input br_taken,
`endif
        output in_valid, input in_ready, output in_instr, output in_opA, output in_opB,
        input  wb_valid, output wb_ready, input wb_we, input wb_rd, input wb_data,
        input  illegal
    );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational instruction decode: opcode/aluop fields to ALU controls and writeback intent.
// bne/blt are decoded only when ALU_ISSUE_BRANCH_EN is defined.
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXC_ADD  = EXC_ADD_DEF,
    parameter logic [DATA_W-1:0] EXC_ADDI = EXC_ADDI_DEF,
    parameter logic [DATA_W-1:0] EXC_SUB  = EXC_SUB_DEF
) (
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [4:0] op;
    logic [4:0] aluop;
    logic       unused_bits;

    assign op          = instr[OP_MSB:OP_LSB];
    assign aluop       = instr[ALUOP_MSB:ALUOP_LSB];
    assign unused_bits = ^{instr[RD_LSB-1:IMM_MSB+1], instr[1:0]};

    always_comb begin
        dec    = '0;
        dec.rd = instr[RD_MSB:RD_LSB];
        case (op)
            OP_RTYPE: begin
                case (aluop)
                    ALU_ADD: begin
                        dec.opcode   = ALU_ADD;
                        dec.exc_code = EXC_ADD;
                    end
                    ALU_SUB: begin
                        dec.opcode   = ALU_SUB;
                        dec.exc_code = EXC_SUB;
                    end
                    ALU_AND, ALU_OR: dec.opcode = aluop;
                    ALU_SLL, ALU_SRA: begin
                        dec.opcode = aluop;
                        dec.shamt  = instr[SHAMT_MSB:SHAMT_LSB];
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec.opcode   = ALU_ADD;
                dec.opb_imm  = 1'b1;
                dec.exc_code = EXC_ADDI;
            end
`ifdef ALU_ISSUE_BRANCH_EN
            // Branch operands arrive as ($rd, $rs); the ALU compares them via subtract.
            OP_BNE: begin
                dec.opcode    = ALU_SUB;
                dec.is_branch = 1'b1;
            end
            OP_BLT: begin
                dec.opcode    = ALU_SUB;
                dec.is_branch = 1'b1;
                dec.br_lt     = 1'b1;
            end
`endif
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.rd = 5'd0;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts an instruction, drives registered ALU inputs for one EXEC
// cycle, then holds a writeback request. ALU_ISSUE_BRANCH_EN adds bne/blt resolution.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter logic [4:0]        RSTATUS_REG = RSTATUS_REG_DEF,
    parameter logic [DATA_W-1:0] EXC_ADD     = EXC_ADD_DEF,
    parameter logic [DATA_W-1:0] EXC_ADDI    = EXC_ADDI_DEF,
    parameter logic [DATA_W-1:0] EXC_SUB     = EXC_SUB_DEF
) (
    input  logic        clock,
    input  logic        reset,
    alu_issue_if.master bus,
    output logic [31:0] alu_opA,
    output logic [31:0] alu_opB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_ne,
    input  logic        alu_lt,
    input  logic        alu_ovf,
    output state_t      fsm_state
);

    state_t  state, state_next;
    decode_t dec;
    logic    ready;
    logic    accept;

    // Per-instruction decode results carried from accept into EXEC.
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] exc_q;
    logic              illegal_q, branch_q, br_lt_q;

    // Writeback payload, written only at the end of EXEC so it stays stable through WB.
    logic              wb_we_q, illegal_wb_q, branch_wb_q;
    logic [4:0]        wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              nxt_we, nxt_taken;
    logic [4:0]        nxt_rd;
    logic [DATA_W-1:0] nxt_data;

    alu_issue_decode #(
        .EXC_ADD (EXC_ADD),
        .EXC_ADDI(EXC_ADDI),
        .EXC_SUB (EXC_SUB)
    ) u_decode (
        .instr(bus.in_instr),
        .dec  (dec)
    );

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) state_next = ST_EXEC;
            end
            ST_EXEC: state_next = ST_WB;
            ST_WB: begin
                if (bus.wb_ready) begin
                    ready      = 1'b1;
                    state_next = bus.in_valid ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept    = bus.in_valid & ready;
    assign fsm_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_opA    <= '0;
            alu_opB    <= '0;
            alu_opcode <= '0;
            alu_shamt  <= '0;
            rd_q       <= '0;
            exc_q      <= '0;
            illegal_q  <= 1'b0;
            branch_q   <= 1'b0;
            br_lt_q    <= 1'b0;
        end else if (accept) begin
            alu_opA    <= bus.in_opA;
            alu_opB    <= dec.opb_imm ? sign_extend_imm(bus.in_instr[IMM_MSB:0]) : bus.in_opB;
            alu_opcode <= dec.opcode;
            alu_shamt  <= dec.shamt;
            rd_q       <= dec.rd;
            exc_q      <= dec.exc_code;
            illegal_q  <= dec.illegal;
            branch_q   <= dec.is_branch;
            br_lt_q    <= dec.br_lt;
        end
    end

    // Overflow redirects the write to the status register and drops the normal result.
    always_comb begin
        nxt_we    = 1'b0;
        nxt_rd    = '0;
        nxt_data  = '0;
        nxt_taken = branch_q & (br_lt_q ? alu_lt : alu_ne);
        if (!illegal_q && !branch_q) begin
            if ((exc_q != '0) && alu_ovf) begin
                nxt_we   = 1'b1;
                nxt_rd   = RSTATUS_REG;
                nxt_data = exc_q;
            end else begin
                nxt_we   = (rd_q != 5'd0);
                nxt_rd   = rd_q;
                nxt_data = alu_result;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            illegal_wb_q <= 1'b0;
            branch_wb_q  <= 1'b0;
        end else if (state == ST_EXEC) begin
            wb_we_q      <= nxt_we;
            wb_rd_q      <= nxt_rd;
            wb_data_q    <= nxt_data;
            illegal_wb_q <= illegal_q;
            branch_wb_q  <= branch_q;
        end
    end

    assign bus.in_ready = ready;
    assign bus.wb_valid = (state == ST_WB);
    assign bus.wb_we    = wb_we_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.illegal  = bus.wb_valid & illegal_wb_q;

`ifdef ALU_ISSUE_BRANCH_EN
    logic br_taken_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 br_taken_q <= 1'b0;
        else if (state == ST_EXEC) br_taken_q <= nxt_taken;
    end

    assign bus.br_valid = bus.wb_valid & branch_wb_q;
    assign bus.br_taken = bus.wb_valid & br_taken_q;
`else
    logic unused_branch;
    assign unused_branch = nxt_taken ^ branch_wb_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a stand-in ALU and an instruction-level model.
// Branch scenarios run when ALU_ISSUE_BRANCH_EN is defined.
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] alu_opA, alu_opB, alu_result;
    logic [4:0]  alu_opcode, alu_shamt;
    logic        alu_ne, alu_lt, alu_ovf;
    state_t      fsm_state;
    int          checks   = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    alu_issue_if bus();

    alu_issue_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .alu_opA   (alu_opA),
        .alu_opB   (alu_opB),
        .alu_opcode(alu_opcode),
        .alu_shamt (alu_shamt),
        .alu_result(alu_result),
        .alu_ne    (alu_ne),
        .alu_lt    (alu_lt),
        .alu_ovf   (alu_ovf),
        .fsm_state (fsm_state)
    );

    // Stand-in for the external combinational alu instance.
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (alu_opcode)
            5'd0: begin
                alu_result = alu_opA + alu_opB;
                alu_ovf = (alu_opA[31] == alu_opB[31]) && (alu_result[31] != alu_opA[31]);
            end
            5'd1: begin
                alu_result = alu_opA - alu_opB;
                alu_ovf = (alu_opA[31] != alu_opB[31]) && (alu_result[31] != alu_opA[31]);
            end
            5'd2: alu_result = alu_opA & alu_opB;
            5'd3: alu_result = alu_opA | alu_opB;
            5'd4: alu_result = alu_opA << alu_shamt;
            5'd5: alu_result = $signed(alu_opA) >>> alu_shamt;
            default: alu_result = '0;
        endcase
        alu_ne = (alu_opA != alu_opB);
        alu_lt = ($signed(alu_opA) < $signed(alu_opB));
    end

    typedef struct packed {
        logic        legal;
        logic        br;
        logic        taken;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] opb;
        logic [4:0]  opcode;
        logic        chk_shamt;
        logic [4:0]  shamt;
    } exp_t;

    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    // Instruction semantics computed with wide signed arithmetic.
    function automatic exp_t ref_model(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [4:0]  op    = instr[31:27];
        logic [4:0]  rd    = instr[26:22];
        logic [4:0]  sh    = instr[11:7];
        logic [4:0]  aop   = instr[6:2];
        logic [16:0] imm   = instr[16:0];
        logic [31:0] immx  = {{15{imm[16]}}, imm};
        longint      wide  = 0;
        logic [31:0] res   = '0;
        logic [31:0] code  = '0;
        bit          arith = 1'b0;
        e = '0;
        e.legal = 1'b1;
        e.opb = b;
        if (op == 5'd0) begin
            e.opcode = aop;
            case (aop)
                5'd0: begin wide = longint'($signed(a)) + longint'($signed(b)); arith = 1; code = 32'd1; end
                5'd1: begin wide = longint'($signed(a)) - longint'($signed(b)); arith = 1; code = 32'd3; end
                5'd2: res = a & b;
                5'd3: res = a | b;
                5'd4: begin res = a << sh; e.chk_shamt = 1; e.shamt = sh; end
                5'd5: begin res = $signed(a) >>> sh; e.chk_shamt = 1; e.shamt = sh; end
                default: e.legal = 1'b0;
            endcase
        end else if (op == 5'd5) begin
            wide = longint'($signed(a)) + longint'($signed(immx));
            arith = 1; code = 32'd2; e.opb = immx; e.opcode = 5'd0;
`ifdef ALU_ISSUE_BRANCH_EN
        end else if (op == 5'd2) begin
            e.br = 1; e.taken = (a != b); e.opcode = 5'd1;
        end else if (op == 5'd6) begin
            e.br = 1; e.taken = ($signed(a) < $signed(b)); e.opcode = 5'd1;
`endif
        end else begin
            e.legal = 1'b0;
        end
        if (arith) res = wide[31:0];
        if (e.legal && !e.br) begin
            if (arith && (wide > MAX_S || wide < MIN_S)) begin
                e.we = 1; e.rd = 5'd30; e.data = code;
            end else begin
                e.we = (rd != 0); e.rd = rd; e.data = res;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] r_instr(input logic [4:0] rd, input logic [4:0] aop, input logic [4:0] sh);
        return {5'd0, rd, 10'($urandom), sh, aop, 2'b00};
    endfunction

    function automatic logic [31:0] i_instr(input logic [4:0] op, input logic [4:0] rd, input logic [16:0] imm);
        return {op, rd, 5'($urandom), imm};
    endfunction

    task automatic run_instr(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                             input int stall, input string name);
        exp_t e = ref_model(instr, a, b);
        int   t = 0;
        bus.in_instr = instr; bus.in_opA = a; bus.in_opB = b; bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && t < 20) begin @(posedge clock); #1; t++; end
        checks++;
        if (t >= 20) begin failures++; $display("FAIL %s ready_timeout in_ready=%b expected 1", name, bus.in_ready); end
        @(posedge clock); #1;
        bus.in_valid = 1'b0; bus.in_instr = $urandom; bus.in_opA = $urandom; bus.in_opB = $urandom;
        checks++;
        if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL %s exec_wb_valid got=%b exp=0", name, bus.wb_valid); end
        if (e.legal) begin
            checks++;
            if (alu_opA !== a || alu_opB !== e.opb || alu_opcode !== e.opcode) begin
                failures++;
                $display("FAIL %s alu_inputs got=%h/%h/%h exp=%h/%h/%h", name, alu_opA, alu_opB, alu_opcode, a, e.opb, e.opcode);
            end
            if (e.chk_shamt) begin
                checks++;
                if (alu_shamt !== e.shamt) begin failures++; $display("FAIL %s alu_shamt got=%0d exp=%0d", name, alu_shamt, e.shamt); end
            end
        end
        @(posedge clock); #1;
        checks++;
        if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL %s latency wb_valid got=%b exp=1", name, bus.wb_valid); end
        for (int s = 0; s <= stall; s++) begin
            checks++;
            if (bus.wb_we !== e.we || bus.illegal !== !e.legal || (!e.br && (bus.wb_rd !== e.rd || bus.wb_data !== e.data))) begin
                failures++;
                $display("FAIL %s wb[%0d] got we=%b ill=%b rd=%0d data=%h exp we=%b ill=%b rd=%0d data=%h",
                         name, s, bus.wb_we, bus.illegal, bus.wb_rd, bus.wb_data, e.we, !e.legal, e.rd, e.data);
            end
`ifdef ALU_ISSUE_BRANCH_EN
            checks++;
            if (bus.br_valid !== e.br || (e.br && bus.br_taken !== e.taken)) begin
                failures++;
                $display("FAIL %s branch got valid=%b taken=%b exp valid=%b taken=%b", name, bus.br_valid, bus.br_taken, e.br, e.taken);
            end
`endif
            if (s < stall) begin
                checks++;
                if (bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b1) begin
                    failures++; $display("FAIL %s stall in_ready=%b wb_valid=%b exp 0/1", name, bus.in_ready, bus.wb_valid);
                end
                @(posedge clock); #1;
            end
        end
        bus.wb_ready = 1'b1;
        @(posedge clock); #1;
        bus.wb_ready = 1'b0;
        checks++;
        if (bus.wb_valid !== 1'b0 || fsm_state !== ST_IDLE) begin
            failures++; $display("FAIL %s retire wb_valid=%b state=%0d exp 0/IDLE", name, bus.wb_valid, fsm_state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (bus.wb_valid !== 0 || alu_opA !== 0 || alu_opB !== 0 || alu_opcode !== 0 || bus.wb_data !== 0 || bus.wb_we !== 0) begin
            failures++; $display("FAIL reset_outputs wb_valid=%b opA=%h opB=%h data=%h exp all 0", bus.wb_valid, alu_opA, alu_opB, bus.wb_data);
        end
        reset = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || fsm_state !== ST_IDLE) begin
            failures++; $display("FAIL reset_ready in_ready=%b state=%0d exp 1/IDLE", bus.in_ready, fsm_state);
        end
    endtask

    task automatic test_directed();
        run_instr(r_instr(5'd3, 5'd0, 5'd0), 32'd5, 32'd7, 0, "add_basic");
        run_instr(i_instr(5'd5, 5'd4, 17'h1FFFF), 32'd10, 32'h12345678, 0, "addi_neg");
        run_instr(r_instr(5'd9, 5'd0, 5'd0), 32'h7FFFFFFF, 32'd1, 0, "add_ovf");
        run_instr(r_instr(5'd9, 5'd1, 5'd0), 32'h80000000, 32'd1, 0, "sub_ovf");
        run_instr(i_instr(5'd5, 5'd6, 17'h00001), 32'h7FFFFFFF, 32'd0, 0, "addi_ovf");
        run_instr(r_instr(5'd0, 5'd0, 5'd0), 32'd1, 32'd2, 0, "add_rd0");
        run_instr(r_instr(5'd7, 5'd4, 5'd31), 32'd1, 32'd0, 0, "sll_31");
        run_instr(r_instr(5'd8, 5'd5, 5'd4), 32'h80000000, 32'd0, 0, "sra_4");
        run_instr(r_instr(5'd2, 5'd3, 5'd0), 32'h7FFFFFFF, 32'h7FFFFFFF, 0, "or_no_ovf");
        run_instr(i_instr(5'd31, 5'd5, 17'h0), 32'd1, 32'd1, 0, "op_illegal");
        run_instr(r_instr(5'd5, 5'd9, 5'd0), 32'd1, 32'd1, 0, "aluop_illegal");
`ifdef ALU_ISSUE_BRANCH_EN
        run_instr(i_instr(5'd2, 5'd0, 17'h0), 32'd3, 32'd3, 0, "bne_equal");
        run_instr(i_instr(5'd6, 5'd0, 17'h0), 32'hFFFFFFFF, 32'd2, 0, "blt_taken");
`else
        run_instr(i_instr(5'd2, 5'd0, 17'h0), 32'd3, 32'd3, 0, "bne_disabled");
`endif
    endtask

    task automatic test_back_to_back();
        bus.in_instr = r_instr(5'd3, 5'd0, 5'd0); bus.in_opA = 32'd5; bus.in_opB = 32'd7; bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.wb_valid !== 1 || bus.in_ready !== 0 || bus.wb_rd !== 5'd3 || bus.wb_data !== 32'd12 || bus.wb_we !== 1) begin
                failures++;
                $display("FAIL b2b_hold[%0d] valid=%b ready=%b rd=%0d data=%h exp 1/0/3/0000000c", i, bus.wb_valid, bus.in_ready, bus.wb_rd, bus.wb_data);
            end
            @(posedge clock); #1;
        end
        bus.in_instr = r_instr(5'd5, 5'd1, 5'd0); bus.in_opA = 32'd50; bus.in_opB = 32'd8; bus.in_valid = 1'b1;
        bus.wb_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready in_ready=%b exp 1", bus.in_ready); end
        @(posedge clock); #1;
        bus.in_valid = 1'b0; bus.wb_ready = 1'b0;
        checks++;
        if (fsm_state !== ST_EXEC || bus.wb_valid !== 0) begin
            failures++; $display("FAIL b2b_exec state=%0d wb_valid=%b exp EXEC/0", fsm_state, bus.wb_valid);
        end
        @(posedge clock); #1;
        checks++;
        if (bus.wb_valid !== 1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'd42) begin
            failures++; $display("FAIL b2b_second valid=%b rd=%0d data=%h exp 1/5/0000002a", bus.wb_valid, bus.wb_rd, bus.wb_data);
        end
        bus.wb_ready = 1'b1;
        @(posedge clock); #1;
        bus.wb_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] edges [4] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
        for (int n = 0; n < 40; n++) begin
            int          kind = $urandom_range(0, 9);
            logic [31:0] a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            logic [31:0] b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            logic [4:0]  rd = 5'($urandom_range(0, 31));
            logic [31:0] instr;
            if (kind <= 5)      instr = r_instr(rd, 5'(kind), 5'($urandom));
            else if (kind == 6) instr = i_instr(5'd5, rd, 17'($urandom));
            else if (kind == 7) instr = i_instr(5'($urandom_range(7, 31)), rd, 17'($urandom));
            else if (kind == 8) instr = r_instr(rd, 5'($urandom_range(6, 31)), 5'($urandom));
            else                instr = i_instr(($urandom_range(0, 1) == 0) ? 5'd2 : 5'd6, rd, 17'($urandom));
            run_instr(instr, a, b, $urandom_range(0, 2), $sformatf("rand%0d", n));
        end
    endtask

    task automatic test_reset_mid();
        bus.in_instr = r_instr(5'd3, 5'd0, 5'd0); bus.in_opA = 32'd5; bus.in_opB = 32'd7; bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (fsm_state !== ST_IDLE || alu_opA !== 0 || bus.wb_valid !== 0) begin
            failures++; $display("FAIL reset_exec state=%0d opA=%h wb_valid=%b exp IDLE/0/0", fsm_state, alu_opA, bus.wb_valid);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.wb_valid !== 0 || bus.in_ready !== 1) begin
                failures++; $display("FAIL reset_drop[%0d] wb_valid=%b in_ready=%b exp 0/1", i, bus.wb_valid, bus.in_ready);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_opA = '0; bus.in_opB = '0; bus.wb_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
